// File: rtl/systolic_pkg.sv
// Shared definitions for the banded systolic MAC array datapath.
// Holds default geometry, common operand/lane types, the operand feeder
// state enum and the helper that computes the last issue cycle of a run.
// The result collector imports the same package so both sides agree on
// geometry and timing.
package systolic_pkg;

  localparam int DEF_LANES      = 5;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_DEPTH      = 8;
  localparam int DEF_SKEW       = 1;
  localparam int DEF_STRIDE     = 3;

  typedef logic [$clog2(DEF_LANES)-1:0] lane_idx_t;
  typedef logic [DEF_DATA_WIDTH-1:0]    data_t;

  typedef enum logic [1:0] {
    FEED_IDLE,
    FEED_RUN,
    FEED_DONE
  } feed_state_e;

  // Cycle index, counted from the first issue cycle, of the last word on
  // the last lane. Only meaningful for l >= 1.
  function automatic int calc_t_last(input int lanes, input int skew,
                                     input int stride, input int l);
    return skew * (lanes - 1) + stride * (l - 1);
  endfunction

endpackage

// File: rtl/feeder_lane_seq.sv
// Per-lane issue sequencer for the operand feeder.
// Looks at the global run counter as it will be in the next cycle and
// decides whether this lane issues a word then, and which word.
// A phase counter that wraps at STRIDE replaces a divide/modulo of t.
// Ports:
//   clk_i, rst_i : clock, synchronous active-high reset
//   run_i        : feeder will be in RUN next cycle
//   t_i          : global run counter value for next cycle
//   offset_i     : cycle of this lane's first issue (SKEW * lane)
//   len_i        : words per lane for the current run
//   issue_o      : this lane issues a word next cycle
//   addr_o       : word index to read for that issue
module feeder_lane_seq #(
  parameter int CW     = 5,
  parameter int LENW   = 4,
  parameter int AW     = 3,
  parameter int STRIDE = 3
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            run_i,
  input  logic [CW-1:0]   t_i,
  input  logic [CW-1:0]   offset_i,
  input  logic [LENW-1:0] len_i,
  output logic            issue_o,
  output logic [AW-1:0]   addr_o
);

  localparam int PW = (STRIDE > 1) ? $clog2(STRIDE) : 1;
  localparam logic [PW-1:0] PHASE_MAX = PW'(STRIDE - 1);

  logic [PW-1:0]   phase_q, phase_d;
  logic [LENW-1:0] word_q, word_d;
  logic            active;

  // The lane is active from its offset until all words are out; inside
  // that window it issues whenever the phase counter is at zero.
  always_comb begin
    active  = run_i && (t_i >= offset_i) && (word_q < len_i);
    issue_o = active && (phase_q == '0);
    phase_d = phase_q;
    word_d  = word_q;
    if (!run_i) begin
      phase_d = '0;
      word_d  = '0;
    end else if (active) begin
      phase_d = (phase_q == PHASE_MAX) ? '0 : phase_q + PW'(1);
      if (issue_o) begin
        word_d = word_q + LENW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      phase_q <= '0;
      word_q  <= '0;
    end else begin
      phase_q <= phase_d;
      word_q  <= word_d;
    end
  end

  assign addr_o = word_q[AW-1:0];

endmodule

// File: rtl/systolic_operand_feeder.sv
// Operand feeder for the banded systolic MAC array.
// Buffers A and B operand bands per lane from a host write port, then on
// start streams them onto the array's A (bottom) and B (left) lanes with
// a per-lane skew and a fixed inter-word stride. Every lane sample has
// its own valid bit; idle lane slots drive zero data and zero valid.
// Ports:
//   clk_i, rst_i       : clock, synchronous active-high reset
//   wr_en_i, wr_sel_i  : buffer write strobe, 0 = A buffer / 1 = B buffer
//   wr_lane_i, wr_addr_i, wr_data_i : write target lane, word index, data
//   len_i              : words per lane, sampled with start (clamped to DEPTH)
//   start_i            : level-sampled launch request
//   busy_o, done_o     : issuing / one-cycle completion pulse
//   a_out_bus_o, valid_bit_a_out_o : A lane data and valids
//   b_out_bus_o, valid_bit_b_out_o : B lane data and valids
module systolic_operand_feeder
  import systolic_pkg::*;
#(
  parameter int LANES      = DEF_LANES,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int SKEW       = DEF_SKEW,
  parameter int STRIDE     = DEF_STRIDE
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             wr_en_i,
  input  logic                             wr_sel_i,
  input  logic [$clog2(LANES)-1:0]         wr_lane_i,
  input  logic [$clog2(DEPTH)-1:0]         wr_addr_i,
  input  logic [DATA_WIDTH-1:0]            wr_data_i,
  input  logic [$clog2(DEPTH+1)-1:0]       len_i,
  input  logic                             start_i,
  output logic                             busy_o,
  output logic                             done_o,
  output logic [LANES-1:0][DATA_WIDTH-1:0] a_out_bus_o,
  output logic [LANES-1:0]                 valid_bit_a_out_o,
  output logic [LANES-1:0][DATA_WIDTH-1:0] b_out_bus_o,
  output logic [LANES-1:0]                 valid_bit_b_out_o
);

  localparam int AW   = $clog2(DEPTH);
  localparam int LENW = $clog2(DEPTH + 1);
  localparam int CW   = $clog2(SKEW * (LANES - 1) + STRIDE * DEPTH + 1);

  feed_state_e state_q, state_d;
  logic [CW-1:0]   t_q, t_d, t_last;
  logic [LENW-1:0] len_q, len_d, len_clamped;
  logic            run_next;
  logic            wr_ok;

  logic [DATA_WIDTH-1:0] mem_a [LANES][DEPTH];
  logic [DATA_WIDTH-1:0] mem_b [LANES][DEPTH];

  logic [LANES-1:0] issue;
  logic [AW-1:0]    rd_addr [LANES];

  logic [LANES-1:0][DATA_WIDTH-1:0] a_bus_q, b_bus_q;
  logic [LANES-1:0]                 a_vld_q, b_vld_q;

  assign len_clamped = (int'(len_i) > DEPTH) ? LENW'(DEPTH) : len_i;
  assign t_last      = CW'(calc_t_last(LANES, SKEW, STRIDE, int'(len_q)));

  // State register with run counter and latched length.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= FEED_IDLE;
      t_q     <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      len_q   <= len_d;
    end
  end

  // Next-state logic. A zero-length run goes straight to DONE so no
  // valid is ever raised. t only counts while in RUN.
  always_comb begin
    state_d = state_q;
    t_d     = '0;
    len_d   = len_q;
    case (state_q)
      FEED_IDLE: begin
        if (start_i) begin
          len_d   = len_clamped;
          state_d = (len_clamped == '0) ? FEED_DONE : FEED_RUN;
        end
      end
      FEED_RUN: begin
        if (t_q == t_last) begin
          state_d = FEED_DONE;
        end else begin
          t_d = t_q + CW'(1);
        end
      end
      FEED_DONE: state_d = FEED_IDLE;
      default:   state_d = FEED_IDLE;
    endcase
  end

  // Output decode. A write coinciding with an accepted start is dropped
  // because the FSM is leaving IDLE in that cycle.
  always_comb begin
    busy_o   = (state_q == FEED_RUN);
    done_o   = (state_q == FEED_DONE);
    run_next = (state_d == FEED_RUN);
    wr_ok    = wr_en_i && (state_q == FEED_IDLE) && !start_i &&
               (int'(wr_lane_i) < LANES);
  end

  // Operand buffers are deliberately left out of reset.
  always_ff @(posedge clk_i) begin
    if (wr_ok) begin
      if (wr_sel_i) begin
        mem_b[wr_lane_i][wr_addr_i] <= wr_data_i;
      end else begin
        mem_a[wr_lane_i][wr_addr_i] <= wr_data_i;
      end
    end
  end

  // Lane sequencers see next-cycle counter values so that the data and
  // valid registers below line up with the issue cycle.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    feeder_lane_seq #(
      .CW     (CW),
      .LENW   (LENW),
      .AW     (AW),
      .STRIDE (STRIDE)
    ) u_seq (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .run_i    (run_next),
      .t_i      (t_d),
      .offset_i (CW'(SKEW * i)),
      .len_i    (len_d),
      .issue_o  (issue[i]),
      .addr_o   (rd_addr[i])
    );
  end

  // Registered lane outputs; A and B of a lane share one sequencer.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      a_bus_q <= '0;
      b_bus_q <= '0;
      a_vld_q <= '0;
      b_vld_q <= '0;
    end else begin
      for (int i = 0; i < LANES; i++) begin
        a_vld_q[i] <= issue[i];
        b_vld_q[i] <= issue[i];
        a_bus_q[i] <= issue[i] ? mem_a[i][rd_addr[i]] : '0;
        b_bus_q[i] <= issue[i] ? mem_b[i][rd_addr[i]] : '0;
      end
    end
  end

  assign a_out_bus_o       = a_bus_q;
  assign b_out_bus_o       = b_bus_q;
  assign valid_bit_a_out_o = a_vld_q;
  assign valid_bit_b_out_o = b_vld_q;

endmodule

// File: tb/tb_systolic_operand_feeder.sv
// Scoreboard testbench for systolic_operand_feeder.
// Stimulus tasks push the expected per-cycle output picture of each run
// into a queue, derived from the issue-time formula over a reference copy
// of the buffers. A negedge monitor pops one entry per cycle (all-zero
// when the queue is empty) and compares it with the DUT outputs.
module tb_systolic_operand_feeder;
  import systolic_pkg::*;

  localparam int LANES  = 5;
  localparam int DEPTH  = 8;
  localparam int SKEW   = 1;
  localparam int STRIDE = 3;

  typedef struct packed {
    logic                  busy;
    logic                  done;
    logic [LANES-1:0]      va;
    logic [LANES-1:0]      vb;
    logic [LANES-1:0][7:0] a;
    logic [LANES-1:0][7:0] b;
  } rec_t;

  logic                  clk;
  logic                  rst;
  logic                  wr_en;
  logic                  wr_sel;
  logic [2:0]            wr_lane;
  logic [2:0]            wr_addr;
  logic [7:0]            wr_data;
  logic [3:0]            len;
  logic                  start;
  logic                  busy;
  logic                  done;
  logic [LANES-1:0][7:0] a_bus;
  logic [LANES-1:0]      a_vld;
  logic [LANES-1:0][7:0] b_bus;
  logic [LANES-1:0]      b_vld;

  data_t refA [LANES][DEPTH];
  data_t refB [LANES][DEPTH];
  rec_t  exp_q [$];
  int    vectors;
  int    errors;
  int    cyc;
  bit    mon_en;

  systolic_operand_feeder dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .wr_en_i           (wr_en),
    .wr_sel_i          (wr_sel),
    .wr_lane_i         (wr_lane),
    .wr_addr_i         (wr_addr),
    .wr_data_i         (wr_data),
    .len_i             (len),
    .start_i           (start),
    .busy_o            (busy),
    .done_o            (done),
    .a_out_bus_o       (a_bus),
    .valid_bit_a_out_o (a_vld),
    .b_out_bus_o       (b_bus),
    .valid_bit_b_out_o (b_vld)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Expected picture of every cycle from the first issue cycle through the
  // done pulse: lane i word k is valid exactly at n = SKEW*i + STRIDE*k.
  task automatic pushRun(input int l);
    rec_t r;
    int   tl;
    if (l == 0) begin
      r      = '0;
      r.done = 1'b1;
      exp_q.push_back(r);
      return;
    end
    tl = SKEW * (LANES - 1) + STRIDE * (l - 1);
    for (int n = 0; n <= tl + 1; n++) begin
      r      = '0;
      r.busy = (n <= tl);
      r.done = (n == tl + 1);
      for (int i = 0; i < LANES; i++) begin
        for (int k = 0; k < l; k++) begin
          if (n == SKEW * i + STRIDE * k) begin
            r.va[i] = 1'b1;
            r.vb[i] = 1'b1;
            r.a[i]  = refA[i][k];
            r.b[i]  = refB[i][k];
          end
        end
      end
      exp_q.push_back(r);
    end
  endtask

  task automatic checkOutput();
    rec_t got;
    rec_t want;
    got.busy = busy;
    got.done = done;
    got.va   = a_vld;
    got.vb   = b_vld;
    got.a    = a_bus;
    got.b    = b_bus;
    want     = '0;
    if (exp_q.size() > 0) want = exp_q.pop_front();
    vectors++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL cycle%0d outputs: got busy=%b done=%b va=%b vb=%b a=%h b=%h, want busy=%b done=%b va=%b vb=%b a=%h b=%h",
               cyc, got.busy, got.done, got.va, got.vb, got.a, got.b,
               want.busy, want.done, want.va, want.vb, want.a, want.b);
    end
  endtask

  always @(negedge clk) if (mon_en) checkOutput();

  // Called one time unit after a rising edge while the feeder is idle.
  task automatic applyWrite(input bit sel, input int lane, input int addr,
                            input logic [7:0] data);
    wr_en   = 1'b1;
    wr_sel  = sel;
    wr_lane = 3'(lane);
    wr_addr = 3'(addr);
    wr_data = data;
    @(posedge clk);
    #1 wr_en = 1'b0;
    if (sel) refB[lane][addr] = data;
    else     refA[lane][addr] = data;
  endtask

  task automatic applyStimulus(input int lenReq);
    int l;
    int nrec;
    len   = 4'(lenReq);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    l    = (lenReq > DEPTH) ? DEPTH : lenReq;
    pushRun(l);
    nrec = (l == 0) ? 1 : SKEW * (LANES - 1) + STRIDE * (l - 1) + 2;
    repeat (nrec) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, vectors=%0d", vectors);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int   tl;
    rec_t idle;
    vectors = 0;
    errors  = 0;
    cyc     = 0;
    mon_en  = 1'b0;
    rst     = 1'b1;
    wr_en   = 1'b0;
    wr_sel  = 1'b0;
    wr_lane = '0;
    wr_addr = '0;
    wr_data = '0;
    len     = '0;
    start   = 1'b0;
    idle    = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    mon_en = 1'b1;

    // Known pattern in both buffers.
    for (int i = 0; i < LANES; i++) begin
      for (int k = 0; k < DEPTH; k++) begin
        applyWrite(1'b0, i, k, 8'(16 * i + k));
        applyWrite(1'b1, i, k, 8'(8'h80 + 16 * i + k));
      end
    end

    applyStimulus(2);
    applyStimulus(0);
    applyStimulus(12);

    // Junk writes every cycle of a run plus a second start mid-run.
    len     = 4'd3;
    start   = 1'b1;
    wr_en   = 1'b1;
    wr_data = 8'hFF;
    @(posedge clk);
    #1 start = 1'b0;
    pushRun(3);
    tl = SKEW * (LANES - 1) + STRIDE * 2;
    for (int n = 0; n < tl + 2; n++) begin
      wr_sel  = 1'($urandom);
      wr_lane = 3'($urandom_range(0, LANES - 1));
      wr_addr = 3'($urandom_range(0, DEPTH - 1));
      start   = (n == 2);
      @(posedge clk);
      #1;
    end
    wr_en = 1'b0;
    start = 1'b0;
    applyStimulus(3);

    // Reset in the third cycle of a run, then restart.
    len   = 4'd2;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    pushRun(2);
    @(posedge clk);
    #1 @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    applyStimulus(2);

    // Randomised buffer updates and run lengths.
    for (int r = 0; r < 6; r++) begin
      repeat ($urandom_range(1, 6)) begin
        applyWrite(1'($urandom), $urandom_range(0, LANES - 1),
                   $urandom_range(0, DEPTH - 1), 8'($urandom));
      end
      applyStimulus($urandom_range(0, 10));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    // Start held high with len=1: three back-to-back runs.
    len   = 4'd1;
    start = 1'b1;
    @(posedge clk);
    #1;
    for (int r = 0; r < 3; r++) begin
      pushRun(1);
      if (r < 2) exp_q.push_back(idle);
    end
    repeat (19) @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    mon_en = 1'b0;
    vectors++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard drain: got %0d entries left, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/systolic_operand_feeder.md
Name: systolic_operand_feeder

Overview:
- Transmit-side companion to the banded systolic MAC array: buffers operand bands A and B per lane.
- On start, streams them onto the array's bottom (A) and left (B) input lanes with the per-lane skew and inter-word stride the array expects.
- Each lane sample carries its own valid bit, so bubbles are explicit.
- Sits between the host/DMA write port and the array's a/b input buses.

Parameters:
- LANES, 5, number of A lanes and number of B lanes (array input bus width).
- DATA_WIDTH, 8, operand bit-width.
- DEPTH, 8, maximum words buffered per lane per operand.
- SKEW, 1, cycle offset between the first issue on lane i and lane i+1.
- STRIDE, 3, cycles between consecutive words on one lane (≥1).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- wr_en  in  1  buffer write strobe
- wr_sel  in  1  0 = A buffer, 1 = B buffer
- wr_lane  in  $clog2(LANES)  target lane
- wr_addr  in  $clog2(DEPTH)  word index within lane
- wr_data  in  DATA_WIDTH  operand word
- len  in  $clog2(DEPTH+1)  words per lane for this run, sampled at start
- start  in  1  launch request (level-sampled)
- busy  out  1  high while issuing
- done  out  1  one-cycle pulse after last issue
- a_out_bus  out  [LANES][DATA_WIDTH]  A lane data to array bottom
- valid_bit_a_out  out  [LANES]  A lane valid
- b_out_bus  out  [LANES][DATA_WIDTH]  B lane data to array left
- valid_bit_b_out  out  [LANES]  B lane valid

Behaviour:
- Reset values: busy=0, done=0, all valid bits=0, all data outputs=0, FSM=IDLE, counters=0.
- Buffer contents are not cleared by reset.
- Writes are accepted only in IDLE. A write while busy or in DONE is dropped.
- FSM states:
  - IDLE: start=1 latches L=min(len,DEPTH) and goes to RUN. With L=0 it goes straight to DONE and no valid is ever issued.
  - RUN: global cycle counter t runs from 0 upward. Goes to DONE after t = T_last = SKEW*(LANES-1) + STRIDE*(L-1).
  - DONE: done=1 for exactly one cycle, then IDLE.
- Timing: start sampled in cycle c → lane 0 word 0 appears on the outputs in cycle c+1 (registered outputs).
- Lane i, word k (0≤k<L) is driven in cycle c+1+SKEW*i+STRIDE*k, with its valid bit high in that cycle only.
- A[i] and B[i] issue on identical cycles.
- Any lane not issuing in a cycle drives data=0 and valid=0.
- busy is high in cycles c+1 through c+1+T_last. done is high in cycle c+2+T_last.
- start is ignored while busy or done. Start is accepted again in the cycle after done.
- A write in the same cycle as an accepted start is dropped: the FSM leaves IDLE that cycle, and writes are IDLE-only.
- Synchronous rst mid-run: next cycle all outputs are 0 and FSM=IDLE; no done pulse.
- No arithmetic on data. Words pass bit-exact.
- Counter width: $clog2(SKEW*(LANES-1)+STRIDE*DEPTH+1).

Decomposition:
- Shared package (systolic_pkg) holds: lane_idx_t, data_t, the feeder FSM state enum, and a function computing T_last from (LANES, SKEW, STRIDE, L). The result collector will reuse the same package.
- One natural sub-module, feeder_lane_seq, instantiated once per lane:
  - Inputs: global t, lane offset, L.
  - Keeps a phase counter modulo STRIDE and a word index.
  - Outputs the read address and an issue flag.
  - Avoids a per-lane divider/modulo.

Test Plan:
- Default params, write A[i][k]=16*i+k and B[i][k]=0x80+16*i+k, len=2, start at c:
  - Lane 0 valid at c+1 (A=0x00, B=0x80) and c+4 (A=0x01, B=0x81).
  - Lane 4 valid at c+5 (A=0x40) and c+8 (A=0x41).
  - busy high c+1..c+8, done at c+9, all other lane cycles valid=0 and data=0.
- len=0 → done one cycle after the start cycle; no valid bit ever rises; busy stays 0.
- len=12 (>DEPTH=8) → clamped to 8. Lane 4's last word (A[4][7]) issues at c+1+4+21=c+26; done at c+27.
- wr_en every cycle while busy with data 0xFF → after run, re-run with same data shows the original values. A second start pulse mid-run → no restart; done is pulsed once.
- rst asserted at c+3 during run → at c+4 all valids=0, busy=0. No done pulse. A new start at c+6 replays the run from word 0.
- Back-to-back: start held high continuously with len=1 → runs repeat. Each run: busy for 5 cycles (T_last=4), then done, then IDLE for one cycle (the cycle after done), where start is re-accepted. Next run's lane 0 issue lands 2 cycles after done.
